// File: rtl/mult_arbiter.sv
// Round-robin arbiter for two requesters sharing one bus-protocol multiplier.
// Sequences load M, load Q, start, wait, read low/high and returns the product.
module mult_arbiter #(
    parameter int n          = 8,
    parameter int START_HOLD = 3400
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [1:0]     req,
    input  logic [n-1:0]   opa0,
    input  logic [n-1:0]   opb0,
    input  logic [n-1:0]   opa1,
    input  logic [n-1:0]   opb1,
    output logic [1:0]     gnt,
    output logic [1:0]     done,
    output logic [2*n-1:0] product,
    output logic [1:0]     mul_func,
    output logic           mul_oe,
    output logic           mul_start,
    input  logic           mul_ready,
    output logic [n-1:0]   mul_dout,
    output logic           mul_drive,
    input  logic [n-1:0]   mul_din
);

    localparam int CW = $clog2(START_HOLD + 2);
    localparam logic [CW-1:0] HOLD_LAST = CW'(START_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_M, S_LOAD_Q, S_START, S_WAIT, S_READ_LO, S_READ_HI, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_pri, w_pri_nxt;
    logic             w_win;
    logic [1:0]       r_gnt, w_gnt_nxt;
    logic [n-1:0]     r_opb, w_opb_nxt;
    logic [n-1:0]     r_lo, w_lo_nxt;
    logic [2*n-1:0]   r_prod, w_prod_nxt;
    logic [n-1:0]     w_dout_nxt;
    logic [1:0]       r_done;
    logic [1:0]       r_func;
    logic             r_oe, r_start, r_drive;
    logic [n-1:0]     r_dout;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pri_nxt   = r_pri;
        w_gnt_nxt   = r_gnt;
        w_opb_nxt   = r_opb;
        w_lo_nxt    = r_lo;
        w_prod_nxt  = r_prod;
        w_dout_nxt  = '0;
        w_win       = req[r_pri] ? r_pri : ~r_pri;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_LOAD_M;
                    w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
                    w_opb_nxt   = w_win ? opb1 : opb0;
                    w_dout_nxt  = w_win ? opa1 : opa0;
                end
            end
            S_LOAD_M: begin
                w_state_nxt = S_LOAD_Q;
                w_dout_nxt  = r_opb;
            end
            S_LOAD_Q: begin
                w_state_nxt = S_START;
                w_cnt_nxt   = '0;
            end
            S_START: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                // First WAIT cycle is unconditional; ready is honoured from the second on.
                if (r_cnt == '0) begin
                    w_cnt_nxt = CW'(1);
                end else if (mul_ready) begin
                    w_state_nxt = S_READ_LO;
                    w_cnt_nxt   = '0;
                end
            end
            S_READ_LO: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt = CW'(1);
                end else begin
                    w_lo_nxt    = mul_din;
                    w_state_nxt = S_READ_HI;
                    w_cnt_nxt   = '0;
                end
            end
            S_READ_HI: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt = CW'(1);
                end else begin
                    w_prod_nxt  = {mul_din, r_lo};
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_pri_nxt   = r_gnt[0];
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pri   <= 1'b0;
            r_gnt   <= '0;
            r_opb   <= '0;
            r_lo    <= '0;
            r_prod  <= '0;
            r_done  <= '0;
            r_func  <= 2'b10;
            r_oe    <= 1'b0;
            r_start <= 1'b0;
            r_drive <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pri   <= w_pri_nxt;
            r_gnt   <= w_gnt_nxt;
            r_opb   <= w_opb_nxt;
            r_lo    <= w_lo_nxt;
            r_prod  <= w_prod_nxt;
            // Bus outputs are registered from the next state so they align with it.
            r_done  <= (w_state_nxt == S_DONE) ? r_gnt : 2'b00;
            case (w_state_nxt)
                S_LOAD_M:  r_func <= 2'b00;
                S_LOAD_Q:  r_func <= 2'b01;
                S_READ_HI: r_func <= 2'b11;
                default:   r_func <= 2'b10;
            endcase
            r_oe    <= (w_state_nxt == S_READ_LO) || (w_state_nxt == S_READ_HI);
            r_start <= (w_state_nxt == S_START);
            r_drive <= (w_state_nxt == S_LOAD_M) || (w_state_nxt == S_LOAD_Q);
            r_dout  <= w_dout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign product   = r_prod;
    assign mul_func  = r_func;
    assign mul_oe    = r_oe;
    assign mul_start = r_start;
    assign mul_drive = r_drive;
    assign mul_dout  = r_dout;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with START_HOLD=4 and a behavioural bus multiplier.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  req;
    logic [7:0]  opa0, opb0, opa1, opb1;
    logic [1:0]  gnt, done;
    logic [15:0] product;
    logic [1:0]  mul_func;
    logic        mul_oe, mul_start, mul_ready, mul_drive;
    logic [7:0]  mul_dout, mul_din;

    int n_asserts = 0;
    int n_fail    = 0;
    logic running = 1'b0;

    mult_arbiter #(.n(8), .START_HOLD(4)) dut (
        .clk(clk), .nreset(nreset), .req(req),
        .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
        .gnt(gnt), .done(done), .product(product),
        .mul_func(mul_func), .mul_oe(mul_oe), .mul_start(mul_start),
        .mul_ready(mul_ready), .mul_dout(mul_dout), .mul_drive(mul_drive),
        .mul_din(mul_din)
    );

    always #5 clk = ~clk;

    // Multiplier model: latches M/Q on driven loads, returns product halves on reads.
    logic [7:0]  m_reg = 8'h00, q_reg = 8'h00;
    logic [15:0] m_prod;
    always @(posedge clk) begin
        if (mul_drive && mul_func == 2'b00) m_reg <= mul_dout;
        if (mul_drive && mul_func == 2'b01) q_reg <= mul_dout;
    end
    always_comb begin
        m_prod  = m_reg * q_reg;
        mul_din = 8'h00;
        if (mul_oe) mul_din = (mul_func == 2'b11) ? m_prod[15:8] : m_prod[7:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            check("bus_drive_oe_excl", {31'b0, mul_drive & mul_oe}, 32'd0);
            check("bus_func_load_undriven", {31'b0, (mul_func[1] == 1'b0) && !mul_drive}, 32'd0);
            check("gnt_onehot0", {31'b0, gnt == 2'b11}, 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   {30'b0, gnt},      32'd0);
        check({tag, "_done"},  {30'b0, done},     32'd0);
        check({tag, "_prod"},  {16'b0, product},  32'd0);
        check({tag, "_func"},  {30'b0, mul_func}, 32'd2);
        check({tag, "_oe"},    {31'b0, mul_oe},   32'd0);
        check({tag, "_start"}, {31'b0, mul_start}, 32'd0);
        check({tag, "_drive"}, {31'b0, mul_drive}, 32'd0);
        check({tag, "_dout"},  {24'b0, mul_dout}, 32'd0);
    endtask

    // Counts negedges until done; gnt checked at cycle gcyc; ready raised at cycle rise.
    task automatic wait_done(input string tag, input logic [1:0] expg, input int gcyc,
                             input logic [15:0] expp, input int lat, input int rise);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == gcyc) check({tag, "_gnt"}, {30'b0, gnt}, {30'b0, expg});
            if (rise != 0 && cyc >= 8 && cyc <= rise)
                check({tag, "_no_read_in_wait"}, {31'b0, mul_oe}, 32'd0);
            if (rise != 0 && cyc == rise) mul_ready = 1'b1;
        end while (done == 2'b00 && cyc < 300);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_done"}, {30'b0, done}, {30'b0, expg});
        check({tag, "_product"}, {16'b0, product}, {16'b0, expp});
    endtask

    task automatic do_op(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] expp, input int rise, input int lat);
        repeat (2) @(negedge clk);
        if (r == 0) begin opa0 = a; opb0 = b; req[0] = 1'b1; end
        else        begin opa1 = a; opb1 = b; req[1] = 1'b1; end
        mul_ready = (rise == 0);
        wait_done(tag, (r == 0) ? 2'b01 : 2'b10, 1, expp, lat, rise);
        req[r] = 1'b0;
        mul_ready = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        nreset = 1'b0;
        req    = 2'b00;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        nreset = 1'b0;
        req = 2'b00;
        opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
        mul_ready = 1'b1;
        repeat (3) @(negedge clk);
        running = 1'b1;
        check_reset_outputs("por");
        nreset = 1'b1;

        do_op("single", 0, 8'd12, 8'd13, 16'd156, 0, 13);
        do_op("max", 1, 8'd255, 8'd255, 16'hFE01, 0, 13);
        do_op("slow_ready", 0, 8'd11, 8'd17, 16'd187, 28, 33);

        do_reset("rst_pre_rr");
        @(negedge clk);
        opa0 = 8'd3; opb0 = 8'd5; opa1 = 8'd7; opb1 = 8'd9;
        req = 2'b11;
        wait_done("rr0", 2'b01, 1, 16'd15, 13, 0);
        wait_done("rr1", 2'b10, 2, 16'd63, 14, 0);
        wait_done("rr2", 2'b01, 2, 16'd15, 14, 0);
        req = 2'b00;

        repeat (2) @(negedge clk);
        opa0 = 8'd100; opb0 = 8'd2;
        req = 2'b01;
        repeat (5) @(negedge clk);
        check("midstart_in_start", {31'b0, mul_start}, 32'd1);
        nreset = 1'b0;
        req = 2'b00;
        #1;
        check_reset_outputs("rst_midstart");
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        do_op("after_rst", 0, 8'd6, 8'd7, 16'd42, 0, 13);

        repeat (3) @(negedge clk);
        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
